// File: rtl/seg7_scroll_scanner.sv
// Multiplexed hex-digit display with a writable, scrollable message buffer.
// Define SEG7_AUTOSCROLL_EN to add a frame timer that steps the window forward every AUTO_PERIOD frames.
module seg7_scroll_scanner #(
    parameter int unsigned DIGITS      = 4,
    parameter int unsigned MSG_DEPTH   = 16,
    parameter int unsigned SLOT_CYCLES = 16,
    parameter int unsigned GUARD       = 3,
    parameter int unsigned AUTO_PERIOD = 1000000,
    localparam int unsigned AW         = $clog2(MSG_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              step_i,
    input  logic              dir_i,
    input  logic              wr_en_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [3:0]        wr_data_i,
    output logic [DIGITS-1:0] an_o,
    output logic [7:0]        seg_o,
    output logic [AW-1:0]     offset_o
);

    localparam int unsigned CW = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;
    localparam int unsigned DW = $clog2(DIGITS);

    localparam logic [CW-1:0] CntLast = CW'(SLOT_CYCLES - 1);
    localparam logic [CW-1:0] GuardLo = CW'(GUARD);
    localparam logic [CW-1:0] GuardHi = CW'(SLOT_CYCLES - 1 - GUARD);
    localparam logic [DW-1:0] DigLast = DW'(DIGITS - 1);
    localparam logic [AW-1:0] IdxLast = AW'(MSG_DEPTH - 1);
    localparam logic [AW:0]   DepthW  = (AW + 1)'(MSG_DEPTH);

    if (2 * GUARD >= SLOT_CYCLES) begin : g_bad_guard
        $error("GUARD too large: 2*GUARD must be below SLOT_CYCLES");
    end
    if (DIGITS < 2 || DIGITS > 8) begin : g_bad_digits
        $error("DIGITS must be in 2..8");
    end
    if (MSG_DEPTH < DIGITS || MSG_DEPTH > 256) begin : g_bad_depth
        $error("MSG_DEPTH must be in DIGITS..256");
    end
    if (AUTO_PERIOD < 1) begin : g_bad_period
        $error("AUTO_PERIOD must be at least 1");
    end

    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     dig_q, dig_d;
    logic [AW-1:0]     offset_q, offset_d;
    logic [AW-1:0]     snap_q, snap_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;
    logic [3:0]        buf_q [MSG_DEPTH];

    logic          last_slot, frame_end;
    logic          adv, adv_dir;
    logic [AW:0]   fetch_raw;
    logic [AW-1:0] fetch_idx;

    function automatic logic [7:0] hex_font(input logic [3:0] ch);
        logic [7:0] f;
        case (ch)
            4'h0:    f = 8'b0000_0011;
            4'h1:    f = 8'b1001_1111;
            4'h2:    f = 8'b0010_0101;
            4'h3:    f = 8'b0000_1101;
            4'h4:    f = 8'b1001_1001;
            4'h5:    f = 8'b0100_1001;
            4'h6:    f = 8'b0100_0001;
            4'h7:    f = 8'b0001_1111;
            4'h8:    f = 8'b0000_0001;
            4'h9:    f = 8'b0000_1001;
            4'hA:    f = 8'b0001_0001;
            4'hB:    f = 8'b1100_0001;
            4'hC:    f = 8'b0110_0011;
            4'hD:    f = 8'b1000_0101;
            4'hE:    f = 8'b0110_0001;
            default: f = 8'b0111_0001;
        endcase
        return f;
    endfunction

`ifdef SEG7_AUTOSCROLL_EN
    localparam int unsigned TW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [TW-1:0] TimerLast = TW'(AUTO_PERIOD - 1);

    logic [TW-1:0] timer_q, timer_d;
    logic          auto_tick;

    always_comb begin
        auto_tick = frame_end && (timer_q == TimerLast);
        timer_d   = timer_q;
        if (frame_end) begin
            timer_d = auto_tick ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else begin
            timer_q <= timer_d;
        end
    end

    // An external step coinciding with a tick replaces it rather than adding to it.
    assign adv     = step_i | auto_tick;
    assign adv_dir = step_i & dir_i;
`else
    assign adv     = step_i;
    assign adv_dir = dir_i;
`endif

    always_comb begin
        last_slot = (cnt_q == CntLast);
        frame_end = last_slot && (dig_q == '0);

        cnt_d = last_slot ? '0 : cnt_q + 1'b1;
        dig_d = dig_q;
        if (last_slot) begin
            dig_d = (dig_q == '0) ? DigLast : dig_q - 1'b1;
        end

        // Snapshot only at frame end so one frame never mixes two offsets.
        snap_d = frame_end ? offset_q : snap_q;

        offset_d = offset_q;
        if (adv) begin
            if (adv_dir) begin
                offset_d = (offset_q == '0) ? IdxLast : offset_q - 1'b1;
            end else begin
                offset_d = (offset_q == IdxLast) ? '0 : offset_q + 1'b1;
            end
        end

        // Sum stays below 2*MSG_DEPTH, so one conditional subtract wraps it.
        fetch_raw = {1'b0, snap_q} + (AW + 1)'(DigLast - dig_q);
        if (fetch_raw >= DepthW) begin
            fetch_idx = AW'(fetch_raw - DepthW);
        end else begin
            fetch_idx = fetch_raw[AW-1:0];
        end

        an_d = '1;
        if (cnt_q >= GuardLo && cnt_q <= GuardHi) begin
            an_d[dig_q] = 1'b0;
        end
        seg_d = hex_font(buf_q[fetch_idx]);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            dig_q    <= DigLast;
            offset_q <= '0;
            snap_q   <= '0;
            an_q     <= '1;
            seg_q    <= 8'hFF;
        end else begin
            cnt_q    <= cnt_d;
            dig_q    <= dig_d;
            offset_q <= offset_d;
            snap_q   <= snap_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MSG_DEPTH; i++) begin
                buf_q[i] <= 4'(i % 16);
            end
        end else if (wr_en_i && ({1'b0, wr_addr_i} < DepthW)) begin
            buf_q[wr_addr_i] <= wr_data_i;
        end
    end

    assign an_o     = an_q;
    assign seg_o    = seg_q;
    assign offset_o = offset_q;

endmodule

// File: tb/tb_seg7_scroll_scanner.sv
// Directed and random stimulus against a cycle-position reference model of the scroll scanner.
module tb_seg7_scroll_scanner;

    localparam int unsigned DIGITS      = 4;
    localparam int unsigned MSG_DEPTH   = 12;
    localparam int unsigned SLOT_CYCLES = 16;
    localparam int unsigned GUARD       = 3;
    localparam int unsigned AUTO_PERIOD = 2;
    localparam int unsigned FRAME       = DIGITS * SLOT_CYCLES;
    localparam int unsigned AW          = $clog2(MSG_DEPTH);

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              step    = 1'b0;
    logic              dir     = 1'b0;
    logic              wr_en   = 1'b0;
    logic [AW-1:0]     wr_addr = '0;
    logic [3:0]        wr_data = '0;
    logic [DIGITS-1:0] an;
    logic [7:0]        seg;
    logic [AW-1:0]     offset;

    always #5 clk = ~clk;

    seg7_scroll_scanner #(
        .DIGITS      (DIGITS),
        .MSG_DEPTH   (MSG_DEPTH),
        .SLOT_CYCLES (SLOT_CYCLES),
        .GUARD       (GUARD),
        .AUTO_PERIOD (AUTO_PERIOD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .step_i    (step),
        .dir_i     (dir),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (wr_data),
        .an_o      (an),
        .seg_o     (seg),
        .offset_o  (offset)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0] font_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                                  8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    // Model: buffer contents, offset, the offset latched for the current frame, frame timer,
    // and p = scan position (cycles since reset release) that the next clock edge will display.
    int mbuf [MSG_DEPTH];
    int moff, msnap, mtimer, p;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s pos=%0d: observed %0h expected %0h", tag, p, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < MSG_DEPTH; i++) mbuf[i] = i % 16;
        moff   = 0;
        msnap  = 0;
        mtimer = 0;
        p      = 0;
    endtask

    task automatic cycle(input logic s, input logic d, input logic we, input int wa,
                         input logic [3:0] wd);
        int slot, dig, noff, nsnap;
        logic [DIGITS-1:0] exp_an;
        logic [7:0] exp_seg;
        bit fend, tick, adv, adir;
        @(negedge clk);
        step    = s;
        dir     = d;
        wr_en   = we;
        wr_addr = AW'(wa);
        wr_data = wd;
        slot    = p % SLOT_CYCLES;
        dig     = DIGITS - 1 - (p / SLOT_CYCLES) % DIGITS;
        exp_an  = '1;
        if (slot >= GUARD && slot < SLOT_CYCLES - GUARD) exp_an[dig] = 1'b0;
        exp_seg = font_tab[mbuf[(msnap + DIGITS - 1 - dig) % MSG_DEPTH]];
        fend    = (p % FRAME) == FRAME - 1;
        tick    = 1'b0;
`ifdef SEG7_AUTOSCROLL_EN
        if (fend) begin
            if (mtimer == AUTO_PERIOD - 1) begin
                tick   = 1'b1;
                mtimer = 0;
            end else begin
                mtimer++;
            end
        end
`endif
        adv   = s || tick;
        adir  = s ? d : 1'b0;
        noff  = !adv ? moff : adir ? (moff + MSG_DEPTH - 1) % MSG_DEPTH : (moff + 1) % MSG_DEPTH;
        nsnap = fend ? moff : msnap;
        @(posedge clk);
        #1;
        check("an", 32'(an), 32'(exp_an));
        check("seg", 32'(seg), 32'(exp_seg));
        check("offset", 32'(offset), noff);
        moff  = noff;
        msnap = nsnap;
        if (we && wa < MSG_DEPTH) mbuf[wa] = int'(wd);
        p++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, 4'h0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset an", 32'(an), 32'hF);
        check("reset seg", 32'(seg), 32'hFF);
        check("reset offset", 32'(offset), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // First frame plus a little: anode walk, guard blanking, reset font.
        idle(FRAME + 4);

        // Three forward steps, then four backward across the 0 -> MSG_DEPTH-1 wrap.
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 0, 4'h0);
            idle(2);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 1'b1, 1'b0, 0, 4'h0);
            idle(3);
        end
        check("offset after wrap", 32'(offset), MSG_DEPTH - 1);
        idle(2 * FRAME);

        // Step in the middle of a frame.
        while (p % FRAME != FRAME / 2) idle(1);
        cycle(1'b1, 1'b0, 1'b0, 0, 4'h0);
        idle(2 * FRAME);

        // In-range write shows up on the second digit; out-of-range writes are dropped.
        cycle(1'b0, 1'b0, 1'b1, 1, 4'hA);
        cycle(1'b0, 1'b0, 1'b1, 12, 4'h5);
        cycle(1'b0, 1'b0, 1'b1, 15, 4'h7);
        idle(2 * FRAME);

        // Step and write in the same cycle.
        cycle(1'b1, 1'b1, 1'b1, 0, 4'hE);
        idle(FRAME);

        for (int i = 0; i < 1500; i++) begin
            cycle($urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                  $urandom_range(0, 5) == 0, int'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)));
        end

        // Asynchronous reset while the third digit is lit.
        while ((p - 1) % FRAME != 40) idle(1);
        check("pre-reset an", 32'(an), 32'hD);
        step  = 1'b1;
        reset = 1'b1;
        #1;
        check("async reset an", 32'(an), 32'hF);
        check("async reset seg", 32'(seg), 32'hFF);
        check("async reset offset", 32'(offset), 0);
        repeat (2) @(posedge clk);
        #1;
        check("held reset offset", 32'(offset), 0);
        @(posedge clk);
        #1;
        step  = 1'b0;
        reset = 1'b0;
        model_reset();
        idle(FRAME + 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
